// File: rtl/seg7_scan_driver.sv
// Multiplexed 4-digit BCD driver for the Nexys4 DDR common-anode display, with guard gaps and per-frame snapshot.
// Optional leading-zero blanking is enabled by defining SEG7_LEADING_ZERO_BLANK_EN.
module seg7_scan_driver #(
    parameter int unsigned DIGIT_CYCLES = 100000,
    parameter int unsigned GUARD_CYCLES = 1000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] ones,
    input  logic [3:0] tens,
    input  logic [3:0] hundreds,
    input  logic [3:0] thousands,
    output logic [7:0] an,
    output logic [6:0] seg,
    output logic       dp,
    output logic       frame_start
);

    localparam int unsigned MAX_CYCLES = (DIGIT_CYCLES > GUARD_CYCLES) ? DIGIT_CYCLES : GUARD_CYCLES;
    localparam int unsigned CW         = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;
    localparam logic [CW-1:0] DIGIT_LAST = CW'(DIGIT_CYCLES - 1);
    localparam logic [CW-1:0] GUARD_LAST = CW'(GUARD_CYCLES - 1);

    typedef enum logic {
        GUARD = 1'b0,
        SHOW  = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [1:0]      idx_q, idx_d;
    logic [3:0][3:0] snap_q;
    logic            capture;
    logic [3:0]      blank;
    logic [7:0]      an_d;
    logic [6:0]      seg_d;

    function automatic logic [6:0] decode(input logic [3:0] d);
        case (d)
            4'd0:    decode = 7'b1000000;
            4'd1:    decode = 7'b1111001;
            4'd2:    decode = 7'b0100100;
            4'd3:    decode = 7'b0110000;
            4'd4:    decode = 7'b0011001;
            4'd5:    decode = 7'b0010010;
            4'd6:    decode = 7'b0000010;
            4'd7:    decode = 7'b1111000;
            4'd8:    decode = 7'b0000000;
            4'd9:    decode = 7'b0010000;
            default: decode = 7'b0111111;
        endcase
    endfunction

`ifdef SEG7_LEADING_ZERO_BLANK_EN
    always_comb begin
        blank    = '0;
        blank[3] = (snap_q[3] == 4'd0);
        blank[2] = blank[3] && (snap_q[2] == 4'd0);
        blank[1] = blank[2] && (snap_q[1] == 4'd0);
    end
`else
    always_comb begin
        blank = '0;
    end
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 1'b1;
        idx_d   = idx_q;
        capture = 1'b0;
        case (state_q)
            GUARD: begin
                if (cnt_q == GUARD_LAST) begin
                    cnt_d   = '0;
                    state_d = SHOW;
                end
            end
            SHOW: begin
                if (cnt_q == DIGIT_LAST) begin
                    cnt_d   = '0;
                    state_d = GUARD;
                    idx_d   = idx_q + 2'd1;
                    capture = (idx_q == 2'd3);
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = GUARD;
            end
        endcase

        // Outputs are derived from the next state so they change on the edge that enters it.
        an_d  = '1;
        seg_d = '1;
        if (state_d == SHOW && !blank[idx_d]) begin
            an_d  = ~(8'h01 << idx_d);
            seg_d = decode(snap_q[idx_d]);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= GUARD;
            cnt_q       <= '0;
            idx_q       <= '0;
            snap_q      <= '0;
            an          <= 8'hFF;
            seg         <= 7'h7F;
            dp          <= 1'b1;
            frame_start <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            an          <= an_d;
            seg         <= seg_d;
            dp          <= 1'b1;
            frame_start <= capture;
            if (capture) begin
                snap_q <= {thousands, hundreds, tens, ones};
            end
        end
    end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Scoreboard bench for seg7_scan_driver: the driver queues hand-computed per-cycle outputs, a negedge monitor checks them.
module tb_seg7_scan_driver;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] ones, tens, hundreds, thousands;
    logic [7:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       frame_start;

    typedef struct {
        logic [7:0] an;
        logic [6:0] seg;
        logic       fs;
        string      tag;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   passes = 0;
    logic mon_en = 1'b0;

`ifdef SEG7_LEADING_ZERO_BLANK_EN
    localparam logic [3:0] BL_0000 = 4'b1110;
    localparam logic [3:0] BL_0070 = 4'b1100;
`else
    localparam logic [3:0] BL_0000 = 4'b0000;
    localparam logic [3:0] BL_0070 = 4'b0000;
`endif

    seg7_scan_driver #(
        .DIGIT_CYCLES(8),
        .GUARD_CYCLES(2)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .ones       (ones),
        .tens       (tens),
        .hundreds   (hundreds),
        .thousands  (thousands),
        .an         (an),
        .seg        (seg),
        .dp         (dp),
        .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] seg_of(input logic [3:0] d);
        case (d)
            4'd0:    seg_of = 7'b1000000;
            4'd1:    seg_of = 7'b1111001;
            4'd2:    seg_of = 7'b0100100;
            4'd3:    seg_of = 7'b0110000;
            4'd4:    seg_of = 7'b0011001;
            4'd5:    seg_of = 7'b0010010;
            4'd6:    seg_of = 7'b0000010;
            4'd7:    seg_of = 7'b1111000;
            4'd8:    seg_of = 7'b0000000;
            4'd9:    seg_of = 7'b0010000;
            default: seg_of = 7'b0111111;
        endcase
    endfunction

    function automatic logic [7:0] an_of(input int p);
        case (p)
            0:       an_of = 8'hFE;
            1:       an_of = 8'hFD;
            2:       an_of = 8'hFB;
            default: an_of = 8'hF7;
        endcase
    endfunction

    task automatic push_one(input logic [7:0] a, input logic [6:0] s, input logic fs, input string tag);
        exp_t e;
        e.an  = a;
        e.seg = s;
        e.fs  = fs;
        e.tag = tag;
        exp_q.push_back(e);
    endtask

    // One frame of expected cycles; guards0 is the guard length of slot 0 (1 right after reset).
    task automatic push_frame(input logic [3:0] d3, input logic [3:0] d2, input logic [3:0] d1,
                              input logic [3:0] d0, input logic fs, input int unsigned guards0,
                              input logic [3:0] blank, input int unsigned limit, input string tag);
        logic [3:0]  d [4];
        int unsigned n;
        int unsigned g;
        d[0] = d0;
        d[1] = d1;
        d[2] = d2;
        d[3] = d3;
        n    = 0;
        for (int p = 0; p < 4; p++) begin
            g = (p == 0) ? guards0 : 2;
            for (int i = 0; i < int'(g); i++) begin
                if (n < limit) begin
                    push_one(8'hFF, 7'h7F, fs && p == 0 && i == 0, $sformatf("%s_p%0d_guard%0d", tag, p, i));
                    n++;
                end
            end
            for (int i = 0; i < 8; i++) begin
                if (n < limit) begin
                    if (blank[p])
                        push_one(8'hFF, 7'h7F, 1'b0, $sformatf("%s_p%0d_blank%0d", tag, p, i));
                    else
                        push_one(an_of(p), seg_of(d[p]), 1'b0, $sformatf("%s_p%0d_show%0d", tag, p, i));
                    n++;
                end
            end
        end
    endtask

    task automatic wait_edges(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            checks++;
            if (exp_q.size() == 0) begin
                $display("FAIL underflow: got an=%h seg=%b fs=%b, required no output pending", an, seg, frame_start);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if ({an, seg, dp, frame_start} !== {e.an, e.seg, 1'b1, e.fs})
                    $display("FAIL %s: got an=%h seg=%b dp=%b fs=%b, required an=%h seg=%b dp=1 fs=%b",
                             e.tag, an, seg, dp, frame_start, e.an, e.seg, e.fs);
                else
                    passes++;
            end
        end
    end

    initial begin
        int n;
        reset     = 1'b1;
        ones      = 4'd1;
        tens      = 4'd2;
        hundreds  = 4'd3;
        thousands = 4'd4;
        wait_edges(3);

        // Edge 0 is the last reset edge; frame 0 shows the reset snapshot.
        push_one(8'hFF, 7'h7F, 1'b0, "reset");
        push_frame(4'd0, 4'd0, 4'd0, 4'd0, 1'b0, 1, BL_0000, 40, "f0");
        push_frame(4'd4, 4'd3, 4'd2, 4'd1, 1'b1, 2, 4'b0000, 40, "f1");
        reset  = 1'b0;
        mon_en = 1'b1;

        wait_edges(50);
        ones      = 4'd5;
        thousands = 4'hC;
        push_frame(4'hC, 4'd3, 4'd2, 4'd5, 1'b1, 2, 4'b0000, 40, "f2");

        wait_edges(50);
        ones = 4'd6;
        push_frame(4'hC, 4'd3, 4'd2, 4'd6, 1'b1, 2, 4'b0000, 40, "f3");

        wait_edges(40);
        ones      = 4'd0;
        tens      = 4'd7;
        hundreds  = 4'd0;
        thousands = 4'd0;
        push_frame(4'd0, 4'd0, 4'd7, 4'd0, 1'b1, 2, BL_0070, 40, "f4");
        push_frame(4'd0, 4'd0, 4'd7, 4'd0, 1'b1, 2, BL_0070, 25, "f5");
        push_one(8'hFF, 7'h7F, 1'b0, "midreset");
        push_frame(4'd0, 4'd0, 4'd0, 4'd0, 1'b0, 1, BL_0000, 39, "r0");

        // Edge 224 leaves position 2 three cycles into its slot; edge 225 applies reset.
        wait_edges(84);
        reset = 1'b1;
        wait_edges(1);
        reset = 1'b0;

        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(posedge clk);
            n++;
        end
        mon_en = 1'b0;
        if (exp_q.size() != 0) begin
            checks++;
            $display("FAIL drain: got %0d entries pending, required 0", exp_q.size());
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/seg7_scan_driver.md
Name: seg7_scan_driver

Overview:
- Consumes the four BCD score digits (ones, tens, hundreds, thousands) from the score-digit counter and drives the Nexys4 DDR 8-digit common-anode display.
- Time-multiplexes digits 0-3 onto the rightmost four positions; digits 4-7 are always off.
- Inserts an all-off guard interval between digits to prevent ghosting.
- Snapshots the inputs once per frame so a digit never changes mid-frame.

Parameters:
- DIGIT_CYCLES, 100000, clk cycles each digit is lit (1 ms at 100 MHz); minimum 1.
- GUARD_CYCLES, 1000, clk cycles with all anodes off before each digit; minimum 1.

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- ones  input  4  BCD digit 0 (rightmost).
- tens  input  4  BCD digit 1.
- hundreds  input  4  BCD digit 2.
- thousands  input  4  BCD digit 3.
- an  output  8  anode enables, active low; an[0] is the rightmost position.
- seg  output  7  cathodes, active low; seg[0]=a ... seg[6]=g.
- dp  output  1  decimal point, active low; held 1 (off).
- frame_start  output  1  one-cycle pulse on the cycle a new snapshot is taken.

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-high. All outputs are registered.
- Reset values:
  - an=8'hFF, seg=7'h7F, dp=1, frame_start=0.
  - State=GUARD, digit index idx=0, cycle counter=0.
  - Snapshot registers snap[0..3]=0.
- State GUARD:
  - an=8'hFF, seg=7'h7F.
  - Counter runs 0..GUARD_CYCLES-1; on terminal count, counter clears and state goes to SHOW.
- State SHOW:
  - an = ~(8'h01 << idx), seg = decode(snap[idx]).
  - Counter runs 0..DIGIT_CYCLES-1; on terminal count, counter clears, idx <= idx+1 mod 4, state goes to GUARD.
- Output timing: an/seg take their new values on the same clk edge that enters the state. No extra latency.
- Snapshot:
  - Taken on the SHOW->GUARD edge where idx wraps 3->0: snap <= {thousands, hundreds, tens, ones}.
  - frame_start=1 for exactly that cycle.
  - The first frame after reset displays 0000 (reset snapshot); the first capture happens at the end of frame 0.
- Frame period: 4*(GUARD_CYCLES+DIGIT_CYCLES) cycles.
- Input changes between snapshots have no effect on outputs.
- Decode (active low, g..a):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001.
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
  - Non-BCD values 10-15 show a dash: 0111111.
- Counter width: $clog2 of max(DIGIT_CYCLES, GUARD_CYCLES), minimum 1 bit. The counter never exceeds its terminal value.
- Reset mid-operation: returns to the reset values on the next edge, regardless of state or counter.

Optional Feature:
- Macro: SEG7_LEADING_ZERO_BLANK_EN.
- Defined:
  - Position 3 is blanked if snap[3]==0.
  - Position 2 is blanked if snap[3:2] are both 0.
  - Position 1 is blanked if snap[3:1] are all 0.
  - Position 0 is never blanked.
  - A blanked position keeps its SHOW slot timing but drives an=8'hFF, seg=7'h7F.
  - Blanking uses the snapshot, not the live inputs.
- Undefined: every position is lit in its slot, including leading zeros.

Test Plan:
- Bench parameters for all cases: DIGIT_CYCLES=8, GUARD_CYCLES=2.
- Reset held 3 cycles -> an=FF, seg=7F, dp=1, frame_start=0. First edge after release: still GUARD. Two cycles later: an=FE, seg=1000000 (snapshot 0), held 8 cycles.
- Inputs ones=1, tens=2, hundreds=3, thousands=4, stable from reset:
  - Frame 0 shows 0000.
  - frame_start pulses once at cycle 40 after reset release.
  - Frame 1 shows an=FE/1111001, FD/0100100, FB/0110000, F7/0011001, each preceded by 2 cycles of an=FF.
- Change ones from 5 to 6 in the middle of a frame -> displayed ones stays 0010010 until the next frame_start, then becomes 0000010.
- thousands=4'hC -> position 3 shows seg=0111111 (dash).
- With SEG7_LEADING_ZERO_BLANK_EN and digits 0,0,7,0 (thousands..ones):
  - Positions 3 and 2 show an=FF in their slots.
  - Position 1 shows an=FD, seg=1111000.
  - Position 0 shows an=FE, seg=1000000.
  - Without the macro, positions 3 and 2 show 0 (1000000).
- Reset asserted during a SHOW of position 2 -> the next edge gives an=FF, idx=0, snapshot=0. The scan restarts with GUARD, then position 0 shows 1000000.
